// File: rtl/lane_fifo_reader.sv
// Read-side controller for a lane FIFO on a dual-port RAM with a 1-cycle read.
// Owns the read pointer, absorbs RAM latency in a 2-entry buffer and presents
// a valid/ready stream. Optional beat counter / high-water mark under
// LANE_FIFO_READER_STATS_EN.
module lane_fifo_reader #(
  parameter int unsigned DATA_WIDTH = 40,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] aso_data,
  output logic                  aso_valid,
  input  logic                  aso_ready,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   usedw,
`ifdef LANE_FIFO_READER_STATS_EN
  output logic [31:0]           rd_count,
  output logic [ADDR_WIDTH:0]   hiwat,
`endif
  output logic                  err_overrun
);

  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = PW'(1) << ADDR_WIDTH;

  logic                  inflight;
  logic [1:0]            held;
  logic [DATA_WIDTH-1:0] tail;

  logic                  pop_c;
  logic                  issue_c;
  logic [2:0]            occ_c;
  logic [1:0]            remain_c;
  logic [1:0]            held_n_c;
  logic [DATA_WIDTH-1:0] head_n_c;
  logic [DATA_WIDTH-1:0] tail_n_c;

  // Occupancy view of the RAM, following the writer combinationally
  always_comb begin
    usedw     = wr_ptr - rd_ptr;
    empty     = (wr_ptr == rd_ptr);
    read_addr = rd_ptr[ADDR_WIDTH-1:0];
  end

  // Issue decision and next contents of the 2-entry output buffer
  always_comb begin
    pop_c    = aso_valid & aso_ready;
    occ_c    = 3'({1'b0, held}) + 3'(inflight) - 3'(pop_c);
    issue_c  = !empty && !flush && (occ_c < 3'd2);
    remain_c = held - 2'(pop_c);
    head_n_c = aso_data;
    tail_n_c = tail;
    if (pop_c) begin
      head_n_c = tail;
    end
    if (inflight) begin
      if (remain_c == 2'd0) begin
        head_n_c = ram_q;
      end else begin
        tail_n_c = ram_q;
      end
    end
    held_n_c = remain_c + 2'(inflight);
  end

  // Read pointer, in-flight flag and buffer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      inflight  <= 1'b0;
      held      <= 2'd0;
      aso_valid <= 1'b0;
      aso_data  <= '0;
      tail      <= '0;
    end else if (flush) begin
      // Old wr_ptr is sampled, so a write on this same edge is kept
      rd_ptr    <= wr_ptr;
      inflight  <= 1'b0;
      held      <= 2'd0;
      aso_valid <= 1'b0;
    end else begin
      if (issue_c) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      inflight  <= issue_c;
      held      <= held_n_c;
      aso_valid <= (held_n_c != 2'd0);
      aso_data  <= head_n_c;
      tail      <= tail_n_c;
    end
  end

  // Sticky flag for a writer that ignored full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overrun <= 1'b0;
    end else if (usedw > DEPTH) begin
      err_overrun <= 1'b1;
    end
  end

`ifdef LANE_FIFO_READER_STATS_EN
  // Stream beat counter (flush-proof) and occupancy high-water mark
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      hiwat    <= '0;
    end else begin
      if (pop_c) begin
        rd_count <= rd_count + 32'd1;
      end
      if (usedw > hiwat) begin
        hiwat <= usedw;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lane_fifo_reader.sv
// Directed bench for lane_fifo_reader with a RAM/writer model and a scoreboard.
// Stats outputs are checked when LANE_FIFO_READER_STATS_EN is defined.
module tb_lane_fifo_reader;

  localparam int unsigned DW = 40;
  localparam int unsigned AW = 9;
  localparam int unsigned PW = AW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] wr_ptr = '0;
  logic [PW-1:0] rd_ptr;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] ram_q = '0;
  logic          flush = 1'b0;
  logic [DW-1:0] aso_data;
  logic          aso_valid;
  logic          aso_ready = 1'b0;
  logic          empty;
  logic [PW-1:0] usedw;
  logic          err_overrun;
`ifdef LANE_FIFO_READER_STATS_EN
  logic [31:0]   rd_count;
  logic [PW-1:0] hiwat;
`endif

  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_skip = 1'b0;
  logic [PW-1:0] skip_n = '0;
  logic          sb_en = 1'b1;
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] exp_q [$];

  int            n_checks = 0;
  int            n_pass = 0;
  int            beats = 0;

  logic          prev_stall = 1'b0;
  logic          prev_flush = 1'b0;
  logic [DW-1:0] prev_data = '0;

  lane_fifo_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr),
    .read_addr  (read_addr),
    .ram_q      (ram_q),
    .flush      (flush),
    .aso_data   (aso_data),
    .aso_valid  (aso_valid),
    .aso_ready  (aso_ready),
    .empty      (empty),
    .usedw      (usedw),
`ifdef LANE_FIFO_READER_STATS_EN
    .rd_count   (rd_count),
    .hiwat      (hiwat),
`endif
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // RAM with registered read (old data on collision) plus the lane writer
  always @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      exp_q.delete();
    end else begin
      if (flush) exp_q.delete();
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr <= wr_ptr + PW'(1);
        if (sb_en) exp_q.push_back(wr_data);
      end else if (wr_skip) begin
        wr_ptr <= wr_ptr + skip_n;
      end
    end
    ram_q <= mem[read_addr];
  end

  // Stream monitor: scoreboard compare on transfers, hold-stability on stalls
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !prev_flush) begin
        chk("stall_valid", 64'(aso_valid), 64'd1);
        chk("stall_data", 64'(aso_data), 64'(prev_data));
      end
      if (aso_valid && aso_ready) begin
        beats = beats + 1;
        if (sb_en) begin
          if (exp_q.size() == 0) chk("unexpected_beat", 64'(aso_data), 64'hdead);
          else chk("sb_data", 64'(aso_data), 64'(exp_q.pop_front()));
        end
      end
      prev_stall = aso_valid && !aso_ready;
      prev_data  = aso_data;
      prev_flush = flush;
    end
  end

  initial begin
    int n_w;
    int bubbles;
    int b0;
    logic [PW-1:0] start;

    foreach (mem[i]) mem[i] = '0;

    // Reset state
    repeat (2) step();
    chk("rst_rd_ptr", 64'(rd_ptr), 64'd0);
    chk("rst_valid", 64'(aso_valid), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_usedw", 64'(usedw), 64'd0);
    chk("rst_err", 64'(err_overrun), 64'd0);
    rst_n = 1'b1;
    step();

    // Single word latency: write at E0, valid after E2
    aso_ready = 1'b1;
    wr_en = 1'b1;
    wr_data = 40'hA5A5A5A5A5;
    step();
    wr_en = 1'b0;
    step();
    chk("lat_e1_valid", 64'(aso_valid), 64'd0);
    step();
    chk("lat_e2_valid", 64'(aso_valid), 64'd1);
    chk("lat_e2_data", 64'(aso_data), 64'hA5A5A5A5A5);
    step();
    chk("lat_empty", 64'(empty), 64'd1);
    chk("lat_rd_ptr", 64'(rd_ptr), 64'd1);
    chk("lat_valid_off", 64'(aso_valid), 64'd0);

    // Fill to full then drain, twice, crossing the pointer wrap
    for (int pass = 0; pass < 2; pass++) begin
      aso_ready = 1'b0;
      n_w = 0;
      while (usedw < PW'(512) && n_w < 2000) begin
        wr_en = 1'b1;
        wr_data = DW'(n_w);
        n_w++;
        step();
      end
      wr_en = 1'b0;
      chk("fill_writes", 64'(n_w), 64'd514);
      chk("fill_usedw", 64'(usedw), 64'd512);
      chk("fill_err", 64'(err_overrun), 64'd0);
      chk("fill_empty", 64'(empty), 64'd0);
      aso_ready = 1'b1;
      bubbles = 0;
      for (int i = 0; i < 514; i++) begin
        @(negedge clk);
        if (!aso_valid) bubbles++;
      end
      repeat (4) step();
      chk("drain_bubbles", 64'(bubbles), 64'd0);
      chk("drain_empty", 64'(empty), 64'd1);
      chk("drain_sb_left", 64'(exp_q.size()), 64'd0);
      chk("drain_rd_ptr", 64'(rd_ptr), (pass == 0) ? 64'd515 : 64'd5);
    end

    // Random back-pressure while writing 100 words
    for (int i = 0; i < 100; i++) begin
      wr_en = 1'b1;
      wr_data = DW'(32'h1000 + i);
      aso_ready = 1'($urandom_range(0, 1));
      step();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      aso_ready = 1'($urandom_range(0, 1));
      step();
    end
    aso_ready = 1'b1;
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) step();
    repeat (3) step();
    chk("rand_sb_left", 64'(exp_q.size()), 64'd0);
    chk("rand_empty", 64'(empty), 64'd1);

    // Flush with a simultaneous write
    aso_ready = 1'b0;
    start = wr_ptr;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1;
      wr_data = DW'(32'h2000 + i);
      step();
    end
    wr_en = 1'b0;
    repeat (4) step();
    chk("stall_issue_limit", 64'(rd_ptr), 64'(start + PW'(2)));
    b0 = beats;
    aso_ready = 1'b1;
    repeat (3) step();
    aso_ready = 1'b0;
    chk("pop3_beats", 64'(beats - b0), 64'd3);
    start = wr_ptr;
    flush = 1'b1;
    wr_en = 1'b1;
    wr_data = 40'h77;
    step();
    flush = 1'b0;
    wr_en = 1'b0;
    chk("flush_valid", 64'(aso_valid), 64'd0);
    chk("flush_rd_ptr", 64'(rd_ptr), 64'(start));
    chk("flush_usedw", 64'(usedw), 64'd1);
    b0 = beats;
    aso_ready = 1'b1;
    repeat (8) step();
    chk("flush_beats", 64'(beats - b0), 64'd1);
    chk("flush_sb_left", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset mid-stream
    aso_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1;
      wr_data = DW'(32'h3000 + i);
      step();
    end
    wr_en = 1'b0;
    repeat (4) step();
    chk("pre_rst_valid", 64'(aso_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(aso_valid), 64'd0);
    chk("arst_rd_ptr", 64'(rd_ptr), 64'd0);
    chk("arst_data", 64'(aso_data), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("arst_empty", 64'(empty), 64'd1);

    // Writer overruns: usedw reaches 513
    sb_en = 1'b0;
    wr_skip = 1'b1;
    skip_n = PW'(513);
    step();
    wr_skip = 1'b0;
    chk("ovr_usedw", 64'(usedw), 64'd513);
    step();
    chk("ovr_err", 64'(err_overrun), 64'd1);
    b0 = beats;
    aso_ready = 1'b1;
    for (int i = 0; i < 200 && (beats - b0) < 20; i++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    aso_ready = 1'b0;
    step();
    chk("ovr_beats", 64'(beats - b0), 64'd20);
    chk("ovr_err_sticky", 64'(err_overrun), 64'd1);
`ifdef LANE_FIFO_READER_STATS_EN
    chk("stats_rd_count", 64'(rd_count), 64'd20);
    chk("stats_hiwat", 64'(hiwat), 64'd513);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
